// File: rtl/posit_decode_pipe.sv
// Two-stage posit operand decoder (sign/flags/magnitude, then regime/exponent/fraction split).
// Optional accepted-word counter enabled by defining POSIT_DECODE_COUNT_EN.
module posit_decode_pipe #(
   parameter int N  = 8,
   parameter int ES = 4,
   parameter int RS = $clog2(N),
   parameter int MW = N - 2,
   parameter int SW = RS + ES + 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_posit,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_sign,
   output logic                 out_zero,
   output logic                 out_nar,
   output logic signed [RS:0]   out_k,
   output logic [ES-1:0]        out_exp,
   output logic signed [SW-1:0] out_scale,
   output logic [MW-1:0]        out_mant,
   output logic [15:0]          dec_count
);

   localparam int FW = MW - 1;
   localparam int EW = ES + FW;
   localparam logic [RS:0] ONE = (RS+1)'(1);

   logic                 s1_valid, s1_sign, s1_zero, s1_nar;
   logic [N-2:0]         s1_mag;
   logic                 s2_valid, s2_sign, s2_zero, s2_nar;
   logic signed [RS:0]   s2_k;
   logic [ES-1:0]        s2_exp;
   logic signed [SW-1:0] s2_scale;
   logic [MW-1:0]        s2_mant;

   logic s2_load, s1_advance, in_fire;

   assign s2_load    = !s2_valid || out_ready;
   assign s1_advance = s1_valid && s2_load;
   assign in_ready   = !s1_valid || s1_advance;
   assign in_fire    = in_valid && in_ready;

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      // NOTE: data registers are reset too, so out_* read as zero straight after reset.
      if (reset) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_zero  <= 1'b0;
         s1_nar   <= 1'b0;
         s1_mag   <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign <= in_posit[N-1];
            s1_zero <= (in_posit == '0);
            s1_nar  <= (in_posit == {1'b1, {(N-1){1'b0}}});
            s1_mag  <= in_posit[N-1] ? (N-1)'(-in_posit) : in_posit[N-2:0];
         end
      end
   end

   logic                 lead, done;
   logic [RS:0]          run;
   logic [N-2:0]         rem;
   logic signed [RS:0]   k_c;
   logic [ES-1:0]        exp_c;
   logic [FW-1:0]        frac_c;
   logic signed [SW-1:0] scale_c;
   logic [MW-1:0]        mant_c;

   // NOTE: every variable gets a value on every path, so no latch is inferred.
   always_comb begin
      lead = s1_mag[N-2];
      run  = '0;
      done = 1'b0;
      for (int i = N - 2; i >= 0; i--) begin
         if (!done && (s1_mag[i] == lead)) run = run + ONE;
         else                              done = 1'b1;
      end
      // A run covering every bit shifts everything out, leaving exp and fraction zero.
      rem             = s1_mag << (run + ONE);
      k_c             = lead ? $signed(run - ONE) : -$signed(run);
      {exp_c, frac_c} = EW'({rem, {EW{1'b0}}} >> (N - 1));
      scale_c         = (SW'(k_c) <<< ES) + SW'($signed({1'b0, exp_c}));
      mant_c          = {1'b1, frac_c};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid <= 1'b0;
         s2_sign  <= 1'b0;
         s2_zero  <= 1'b0;
         s2_nar   <= 1'b0;
         s2_k     <= '0;
         s2_exp   <= '0;
         s2_scale <= '0;
         s2_mant  <= '0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_nar  <= s1_nar;
            if (s1_zero || s1_nar) begin
               s2_k     <= '0;
               s2_exp   <= '0;
               s2_scale <= '0;
               s2_mant  <= '0;
            end else begin
               s2_k     <= k_c;
               s2_exp   <= exp_c;
               s2_scale <= scale_c;
               s2_mant  <= mant_c;
            end
         end
      end
   end

   assign out_valid = s2_valid;
   assign out_sign  = s2_sign;
   assign out_zero  = s2_zero;
   assign out_nar   = s2_nar;
   assign out_k     = s2_k;
   assign out_exp   = s2_exp;
   assign out_scale = s2_scale;
   assign out_mant  = s2_mant;

`ifdef POSIT_DECODE_COUNT_EN
   logic [15:0] count_q;

   always_ff @(posedge clk) begin
      if (reset)        count_q <= '0;
      else if (in_fire) count_q <= count_q + 16'd1;
   end

   assign dec_count = count_q;
`else
   logic unused_fire;
   assign unused_fire = in_fire;
   assign dec_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Scoreboard bench for posit_decode_pipe (N=8, ES=4): directed words with hand-decoded fields.
module tb_posit_decode_pipe;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid, in_ready, out_valid, out_ready;
   logic [7:0]        in_posit;
   logic              out_sign, out_zero, out_nar;
   logic [3:0]        out_k;
   logic [3:0]        out_exp;
   logic [8:0]        out_scale;
   logic [5:0]        out_mant;
   logic [15:0]       dec_count;

   typedef struct {
      logic [7:0] w;
      logic       sign, zero, nar;
      logic [3:0] k;
      logic [3:0] e;
      logic [8:0] scale;
      logic [5:0] mant;
   } vec_t;

   vec_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   acc_cnt = 0;

   always #5 clk = ~clk;

   posit_decode_pipe dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_posit(in_posit),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_zero(out_zero), .out_nar(out_nar),
      .out_k(out_k), .out_exp(out_exp), .out_scale(out_scale), .out_mant(out_mant),
      .dec_count(dec_count)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] w, input logic s, input logic z, input logic n,
                               input int k, input int e, input int sc, input logic [5:0] m);
      vec_t v;
      v.w = w; v.sign = s; v.zero = z; v.nar = n;
      v.k = 4'(k); v.e = 4'(e); v.scale = 9'(sc); v.mant = m;
      return v;
   endfunction

   function automatic logic [15:0] exp_count();
`ifdef POSIT_DECODE_COUNT_EN
      return 16'(acc_cnt);
`else
      return 16'h0000;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input vec_t v);
      int n = 0;
      in_posit = v.w;
      in_valid = 1'b1;
      q.push_back(v);
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check($sformatf("accept_timeout_%02h", v.w), 0, 1);
         void'(q.pop_back());
      end else begin
         @(posedge clk);
         #1;
         acc_cnt++;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (q.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", q.size(), 0);
   endtask

   // Monitor: pops the oldest expectation on every output transfer.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (q.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            vec_t e;
            e = q.pop_front();
            check($sformatf("sign_%02h", e.w),  out_sign,  e.sign);
            check($sformatf("zero_%02h", e.w),  out_zero,  e.zero);
            check($sformatf("nar_%02h", e.w),   out_nar,   e.nar);
            check($sformatf("k_%02h", e.w),     out_k,     e.k);
            check($sformatf("exp_%02h", e.w),   out_exp,   e.e);
            check($sformatf("scale_%02h", e.w), out_scale, e.scale);
            check($sformatf("mant_%02h", e.w),  out_mant,  e.mant);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t vecs[11];
   vec_t v4d, v01, v7f;

   initial begin
      v4d     = mk(8'h4D, 0, 0, 0,  0,  6,   6, 6'b110000);
      v01     = mk(8'h01, 0, 0, 0, -6,  0, -96, 6'b100000);
      v7f     = mk(8'h7F, 0, 0, 0,  6,  0,  96, 6'b100000);
      vecs[0] = v4d;
      vecs[1] = v01;
      vecs[2] = v7f;
      vecs[3] = mk(8'hF3, 1, 0, 0, -3, 10, -38, 6'b100000);
      vecs[4] = mk(8'h00, 0, 1, 0,  0,  0,   0, 6'b000000);
      vecs[5] = mk(8'h80, 1, 0, 1,  0,  0,   0, 6'b000000);
      vecs[6] = mk(8'h40, 0, 0, 0,  0,  0,   0, 6'b100000);
      vecs[7] = mk(8'hC0, 1, 0, 0,  0,  0,   0, 6'b100000);
      vecs[8] = mk(8'h7E, 0, 0, 0,  5,  0,  80, 6'b100000);
      vecs[9] = mk(8'h5F, 0, 0, 0,  0, 15,  15, 6'b110000);
      vecs[10] = mk(8'hFF, 1, 0, 0, -6, 0, -96, 6'b100000);

      reset = 1'b1; in_valid = 1'b0; in_posit = '0; out_ready = 1'b1;
      step();
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_scale", out_scale, 0);
      check("rst_mant", out_mant, 0);
      check("rst_count", dec_count, 0);
      step();
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);

      // Latency: word lands in S1 after the accepting edge, in S2 one edge later.
      step();
      send(v4d);
      @(negedge clk);
      check("lat_s1_out_valid", out_valid, 0);
      @(negedge clk);
      check("lat_s2_out_valid", out_valid, 1);
      wait_drain();

      // Back-to-back stream of every vector with the consumer always ready.
      step();
      foreach (vecs[i]) send(vecs[i]);
      wait_drain();
      check("count_stream", dec_count, exp_count());

      // Backpressure: two words fill the pipe, the third waits until release.
      step();
      out_ready = 1'b0;
      send(v4d);
      send(v01);
      fork
         send(v7f);
         begin
            repeat (4) begin
               @(negedge clk);
               check("stall_out_valid", out_valid, 1);
               check("stall_in_ready", in_ready, 0);
               check("stall_scale", out_scale, 9'd6);
               check("stall_mant", out_mant, 6'b110000);
            end
            step();
            out_ready = 1'b1;
         end
      join
      wait_drain();

      // Reset with both stages full discards the in-flight words.
      step();
      out_ready = 1'b0;
      send(vecs[3]);
      send(vecs[9]);
      reset = 1'b1;
      step();
      reset = 1'b0;
      q.delete();
      acc_cnt = 0;
      @(negedge clk);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_count", dec_count, 0);
      repeat (3) begin
         @(negedge clk);
         check("mid_rst_no_output", out_valid, 0);
      end
      step();
      out_ready = 1'b1;
      send(vecs[5]);
      send(vecs[4]);
      send(vecs[10]);
      wait_drain();
      check("count_after_reset", dec_count, exp_count());

      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
